sprite_blitter: RTL and testbench
=================================

# sprite_blitter

Parametrised sprite rendering engine for the game's VGA path. It is the successor to the fixed 4x4 red-square drawer. On one start handshake it restores the background under the sprite's old position, then draws a ROM-sourced, transparency-keyed, screen-clipped sprite at the new position. It emits one pixel write per clock to the VGA adapter's plot/x/y/colour inputs and sits between the sprite movement FSM and the VGA adapter.

## Interface
- SPRITE_W, 4: sprite width in pixels (power of two not required)
- SPRITE_H, 4: sprite height in pixels
- X_W, 9: x coordinate width
- Y_W, 8: y coordinate width
- COLOR_W, 3: colour width
- SCREEN_W, 320: pixels with x >= SCREEN_W are clipped
- SCREEN_H, 240: pixels with y >= SCREEN_H are clipped
- TRANSPARENT, 0: sprite colour value that is never plotted
- Clock and reset: one clock; reset is synchronous and active-high.
- clock  in  1  system clock, all logic on posedge
- reset  in  1  synchronous, active-high
- start  in  1  request; sampled only in IDLE
- mode  in  2  01 draw only, 10 erase only, 11 erase then draw, 00 no-op
- old_x / old_y  in  X_W / Y_W  top-left corner of the erase region
- new_x / new_y  in  X_W / Y_W  top-left corner of the draw region
- bg_x / bg_y  out  X_W / Y_W  background ROM address (absolute pixel), combinational from the counters
- bg_color  in  COLOR_W  background ROM data, valid 1 cycle after its address
- spr_addr  out  clog2(SPRITE_W*SPRITE_H)  sprite ROM address = cy*SPRITE_W + cx
- spr_color  in  COLOR_W  sprite ROM data, valid 1 cycle after its address
- x / y  out  X_W / Y_W  VGA pixel coordinate (registered)
- color  out  COLOR_W  VGA pixel colour (registered)
- plot  out  1  VGA write enable (registered)
- busy  out  1  high while a request is in progress
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, ERASE, DRAW, DONE.
- Transitions:
  - IDLE to ERASE on start with mode[1]=1.
  - IDLE to DRAW on start with mode=01.
  - start with mode=00 is ignored; the block stays in IDLE and does not pulse done.
- On acceptance, old_x/old_y, new_x/new_y and mode are latched. Later input changes have no effect on the current request.
- ERASE/DRAW walk the counters (cx, cy) raster order: cx from 0 to SPRITE_W-1 (inner), then cy from 0 to SPRITE_H-1. One pixel is issued per clock. Counters clear on entry to each phase.
- ERASE pixel: coordinate = (old_x+cx, old_y+cy); colour = bg_color.
- ERASE exit: to DRAW if mode[0]=1, else to DONE.
- DRAW pixel: coordinate = (new_x+cx, new_y+cy); colour = spr_color.
- DRAW exit: always to DONE.
- DONE lasts exactly one cycle (done=1), then returns to IDLE.
- Coordinate sums are computed at X_W+1 / Y_W+1 bits. A pixel is clipped, with plot=0 for that slot, if sum >= SCREEN_W/SCREEN_H, including sums that overflow X_W/Y_W.
- DRAW pixels whose spr_color == TRANSPARENT get plot=0.
- Clipped and transparent pixels still consume their cycle, so latency is data-independent.
- start is ignored in every state except IDLE, including the DONE cycle.

## Timing
- Reset values:
  - state=IDLE, counters=0
  - plot=0, busy=0, done=0
  - x=0, y=0, color=0
  - bg_x/bg_y/spr_addr reflect the zeroed counters and latches
- Define N = SPRITE_W*SPRITE_H. start is accepted at posedge cycle 0.
- Phase 1 addresses are issued in cycles 1..N. Pixel k's ROM data arrives in cycle k+1. x/y/color/plot for pixel k are visible in cycle k+2.
- Two-phase request: DRAW addresses in cycles N+1..2N; plots in cycles 3..2N+2; done in cycle 2N+3.
- Single-phase request: plots in cycles 3..N+2; done in cycle N+3.
- busy=1 from cycle 1 through the done cycle inclusive. The earliest next acceptance is the cycle after done.
- plot is contiguous across the ERASE to DRAW boundary, with no bubble.
- Reset mid-operation: the next cycle shows IDLE with plot=0, busy=0, done=0. The interrupted request never pulses done.

## Test plan
- Default parameters, mode=11, old=(10,20), new=(11,20), bg ROM = (x+y) mod 8, sprite ROM all 3'b100 → 32 plots in cycles 3..34.
  - First plot (10,20) with colour 6; plot 16 at (11,20) with colour 4.
  - done in cycle 35 only; busy high in cycles 1..35.
- mode=01, new=(318,238), sprite all non-transparent → only the 4 pixels with cx<2 and cy<2 plot. done still in cycle 19.
- Sprite ROM with index 5 = TRANSPARENT, mode=01 → 15 plots; the slot for (new_x+1, new_y+1) has plot=0.
- Same as the transparency test, but sprite ROM with index 5 = 3'b111 and TRANSPARENT=3'b111 → identical result, confirming the TRANSPARENT parameter is honoured.
- Second start held high through busy and during the done cycle → ignored; accepted on the first IDLE cycle. mode=00 start → no busy, no done.
- reset asserted in cycle 10 of a mode=11 request → plot=0, busy=0 from cycle 11; no done ever.
- SPRITE_W=8, SPRITE_H=2, mode=10 → 16 erase plots, raster order (x0..x0+7, y0) then (x0..x0+7, y0+1); done in cycle 19.

Source files
------------

// File: rtl/sprite_blitter.sv
// Sprite blitter: restores the background under the sprite's old position, then draws a
// ROM-sourced, transparency-keyed, screen-clipped sprite at its new position. It issues one
// pixel slot per clock through a two-stage pipeline that matches the one-cycle ROM latency.
module sprite_blitter #(
  parameter int unsigned SPRITE_W    = 4,
  parameter int unsigned SPRITE_H    = 4,
  parameter int unsigned X_W         = 9,
  parameter int unsigned Y_W         = 8,
  parameter int unsigned COLOR_W     = 3,
  parameter int unsigned SCREEN_W    = 320,
  parameter int unsigned SCREEN_H    = 240,
  parameter int unsigned TRANSPARENT = 0,
  localparam int unsigned N   = SPRITE_W * SPRITE_H,
  localparam int unsigned AW  = (N > 1) ? $clog2(N) : 1,
  localparam int unsigned CXW = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1,
  localparam int unsigned CYW = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [1:0]         i_mode,
  input  logic [X_W-1:0]     i_old_x,
  input  logic [Y_W-1:0]     i_old_y,
  input  logic [X_W-1:0]     i_new_x,
  input  logic [Y_W-1:0]     i_new_y,
  output logic [X_W-1:0]     o_bg_x,
  output logic [Y_W-1:0]     o_bg_y,
  input  logic [COLOR_W-1:0] i_bg_color,
  output logic [AW-1:0]      o_spr_addr,
  input  logic [COLOR_W-1:0] i_spr_color,
  output logic [X_W-1:0]     o_x,
  output logic [Y_W-1:0]     o_y,
  output logic [COLOR_W-1:0] o_color,
  output logic               o_plot,
  output logic               o_busy,
  output logic               o_done
);

  typedef enum logic [1:0] {StIdle, StErase, StDraw, StDone} state_e;

  state_e r_state;
  state_e w_state_next;

  // Latched request
  logic [1:0]     r_mode;
  logic [X_W-1:0] r_old_x;
  logic [Y_W-1:0] r_old_y;
  logic [X_W-1:0] r_new_x;
  logic [Y_W-1:0] r_new_y;

  // Raster counters; r_drain marks that the final phase has issued its last slot and the
  // pipeline is emptying before the done cycle.
  logic [CXW-1:0] r_cx;
  logic [CYW-1:0] r_cy;
  logic           r_drain;

  // Stage 1: slot address side, aligned with ROM data
  logic           r_p1_live;
  logic           r_p1_draw;
  logic           r_p1_clip;
  logic [X_W-1:0] r_p1_x;
  logic [Y_W-1:0] r_p1_y;

  // Stage 2: registered VGA outputs
  logic               r_plot;
  logic [X_W-1:0]     r_x;
  logic [Y_W-1:0]     r_y;
  logic [COLOR_W-1:0] r_color;

  logic           w_accept;
  logic           w_last_px;
  logic           w_last_cx;
  logic           w_issue;
  logic           w_busy;
  logic           w_done;
  logic [X_W:0]   w_sum_x;
  logic [Y_W:0]   w_sum_y;
  logic [X_W:0]   w_bg_sum_x;
  logic [Y_W:0]   w_bg_sum_y;
  logic           w_clip;
  logic           w_transparent;

  assign w_accept  = i_start && (i_mode != 2'b00);
  assign w_last_cx = (r_cx == CXW'(SPRITE_W - 1));
  assign w_last_px = w_last_cx && (r_cy == CYW'(SPRITE_H - 1));

  // Coordinate sums carry one extra bit so overflowing sums are clipped, not wrapped
  assign w_sum_x = (r_state == StDraw) ? ({1'b0, r_new_x} + (X_W + 1)'(r_cx))
                                       : ({1'b0, r_old_x} + (X_W + 1)'(r_cx));
  assign w_sum_y = (r_state == StDraw) ? ({1'b0, r_new_y} + (Y_W + 1)'(r_cy))
                                       : ({1'b0, r_old_y} + (Y_W + 1)'(r_cy));
  assign w_clip  = (int'(w_sum_x) >= int'(SCREEN_W)) || (int'(w_sum_y) >= int'(SCREEN_H));

  assign w_bg_sum_x = {1'b0, r_old_x} + (X_W + 1)'(r_cx);
  assign w_bg_sum_y = {1'b0, r_old_y} + (Y_W + 1)'(r_cy);
  assign o_bg_x     = w_bg_sum_x[X_W-1:0];
  assign o_bg_y     = w_bg_sum_y[Y_W-1:0];
  assign o_spr_addr = AW'(int'(r_cy) * int'(SPRITE_W) + int'(r_cx));

  assign w_transparent = (i_spr_color == COLOR_W'(TRANSPARENT));

  // State register
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; leave a phase only once the last slot has left stage 1
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (i_start && i_mode[1]) begin
          w_state_next = StErase;
        end else if (i_start && (i_mode == 2'b01)) begin
          w_state_next = StDraw;
        end
      end
      StErase: begin
        if (!r_drain && w_last_px && r_mode[0]) begin
          w_state_next = StDraw;
        end else if (r_drain && !r_p1_live) begin
          w_state_next = StDone;
        end
      end
      StDraw: begin
        if (r_drain && !r_p1_live) begin
          w_state_next = StDone;
        end
      end
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    w_busy  = 1'b0;
    w_done  = 1'b0;
    w_issue = 1'b0;
    unique case (r_state)
      StIdle:  ;
      StErase: begin
        w_busy  = 1'b1;
        w_issue = !r_drain;
      end
      StDraw: begin
        w_busy  = 1'b1;
        w_issue = !r_drain;
      end
      StDone: begin
        w_busy = 1'b1;
        w_done = 1'b1;
      end
      default: ;
    endcase
  end

  // Request latch, raster counters and drain flag
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_mode  <= 2'b00;
      r_old_x <= '0;
      r_old_y <= '0;
      r_new_x <= '0;
      r_new_y <= '0;
      r_cx    <= '0;
      r_cy    <= '0;
      r_drain <= 1'b0;
    end else if ((r_state == StIdle) && w_accept) begin
      r_mode  <= i_mode;
      r_old_x <= i_old_x;
      r_old_y <= i_old_y;
      r_new_x <= i_new_x;
      r_new_y <= i_new_y;
      r_cx    <= '0;
      r_cy    <= '0;
      r_drain <= 1'b0;
    end else if (w_issue) begin
      if (w_last_px) begin
        r_cx <= '0;
        r_cy <= '0;
        // An erase followed by a draw rolls straight into the next phase with no bubble
        if (!((r_state == StErase) && r_mode[0])) begin
          r_drain <= 1'b1;
        end
      end else if (w_last_cx) begin
        r_cx <= '0;
        r_cy <= r_cy + 1'b1;
      end else begin
        r_cx <= r_cx + 1'b1;
      end
    end else if (r_state == StDone) begin
      r_drain <= 1'b0;
    end
  end

  // Stage 1: capture slot coordinate and clip while the ROMs fetch
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_p1_live <= 1'b0;
      r_p1_draw <= 1'b0;
      r_p1_clip <= 1'b0;
      r_p1_x    <= '0;
      r_p1_y    <= '0;
    end else begin
      r_p1_live <= w_issue;
      r_p1_draw <= (r_state == StDraw);
      r_p1_clip <= w_clip;
      r_p1_x    <= w_sum_x[X_W-1:0];
      r_p1_y    <= w_sum_y[Y_W-1:0];
    end
  end

  // Stage 2: register the VGA write; clipped and transparent slots keep plot low
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_plot  <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
      r_color <= '0;
    end else begin
      r_plot <= r_p1_live && !r_p1_clip && !(r_p1_draw && w_transparent);
      if (r_p1_live) begin
        r_x     <= r_p1_x;
        r_y     <= r_p1_y;
        r_color <= r_p1_draw ? i_spr_color : i_bg_color;
      end
    end
  end

  assign o_plot  = r_plot;
  assign o_x     = r_x;
  assign o_y     = r_y;
  assign o_color = r_color;
  assign o_busy  = w_busy;
  assign o_done  = w_done;

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter: three instances (default, TRANSPARENT=7, 8x2 sprite)
// share stimulus; sel picks which one receives start and is observed.
module tb_sprite_blitter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [8:0] old_x = '0;
  logic [7:0] old_y = '0;
  logic [8:0] new_x = '0;
  logic [7:0] new_y = '0;
  int         sel = 0;

  int n_vec = 0;
  int n_err = 0;

  logic [2:0] spr_rom [16];

  always #5 clk = ~clk;

  logic [8:0] bg_x [3];
  logic [7:0] bg_y [3];
  logic [3:0] spr_addr [3];
  logic [2:0] bg_col [3];
  logic [2:0] spr_col [3];
  logic [8:0] o_x [3];
  logic [7:0] o_y [3];
  logic [2:0] o_col [3];
  logic       o_plot [3];
  logic       o_busy [3];
  logic       o_done [3];

  // Registered ROM models: data valid one cycle after the address
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      bg_col[i]  <= 3'((int'(bg_x[i]) + int'(bg_y[i])) % 8);
      spr_col[i] <= spr_rom[spr_addr[i]];
    end
  end

  sprite_blitter u_dut0 (
    .i_clock(clk), .i_reset(rst), .i_start(start && (sel == 0)), .i_mode(mode),
    .i_old_x(old_x), .i_old_y(old_y), .i_new_x(new_x), .i_new_y(new_y),
    .o_bg_x(bg_x[0]), .o_bg_y(bg_y[0]), .i_bg_color(bg_col[0]),
    .o_spr_addr(spr_addr[0]), .i_spr_color(spr_col[0]),
    .o_x(o_x[0]), .o_y(o_y[0]), .o_color(o_col[0]),
    .o_plot(o_plot[0]), .o_busy(o_busy[0]), .o_done(o_done[0])
  );

  sprite_blitter #(.TRANSPARENT(7)) u_dut1 (
    .i_clock(clk), .i_reset(rst), .i_start(start && (sel == 1)), .i_mode(mode),
    .i_old_x(old_x), .i_old_y(old_y), .i_new_x(new_x), .i_new_y(new_y),
    .o_bg_x(bg_x[1]), .o_bg_y(bg_y[1]), .i_bg_color(bg_col[1]),
    .o_spr_addr(spr_addr[1]), .i_spr_color(spr_col[1]),
    .o_x(o_x[1]), .o_y(o_y[1]), .o_color(o_col[1]),
    .o_plot(o_plot[1]), .o_busy(o_busy[1]), .o_done(o_done[1])
  );

  sprite_blitter #(.SPRITE_W(8), .SPRITE_H(2)) u_dut2 (
    .i_clock(clk), .i_reset(rst), .i_start(start && (sel == 2)), .i_mode(mode),
    .i_old_x(old_x), .i_old_y(old_y), .i_new_x(new_x), .i_new_y(new_y),
    .o_bg_x(bg_x[2]), .o_bg_y(bg_y[2]), .i_bg_color(bg_col[2]),
    .o_spr_addr(spr_addr[2]), .i_spr_color(spr_col[2]),
    .o_x(o_x[2]), .o_y(o_y[2]), .o_color(o_col[2]),
    .o_plot(o_plot[2]), .o_busy(o_busy[2]), .o_done(o_done[2])
  );

  // Captured outputs, index = cycle number after acceptance
  logic       cp_plot [64];
  logic       cp_busy [64];
  logic       cp_done [64];
  logic [8:0] cp_x [64];
  logic [7:0] cp_y [64];
  logic [2:0] cp_col [64];

  task automatic fill_spr(input logic [2:0] v);
    for (int i = 0; i < 16; i++) spr_rom[i] = v;
  endtask

  task automatic launch(input logic [1:0] m, input int ox, input int oy, input int nx,
                        input int ny);
    @(negedge clk);
    mode  = m;
    old_x = 9'(ox);
    old_y = 8'(oy);
    new_x = 9'(nx);
    new_y = 8'(ny);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic capture(input int ncyc);
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      cp_plot[c] = o_plot[sel];
      cp_busy[c] = o_busy[sel];
      cp_done[c] = o_done[sel];
      cp_x[c]    = o_x[sel];
      cp_y[c]    = o_y[sel];
      cp_col[c]  = o_col[sel];
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++; if (o_plot[0] !== 1'b0) begin n_err++; $display("FAIL reset plot got %0b want 0", o_plot[0]); end
    n_vec++; if (o_busy[0] !== 1'b0) begin n_err++; $display("FAIL reset busy got %0b want 0", o_busy[0]); end
    n_vec++; if (o_done[0] !== 1'b0) begin n_err++; $display("FAIL reset done got %0b want 0", o_done[0]); end
    n_vec++; if (o_x[0] !== 9'd0) begin n_err++; $display("FAIL reset x got %0d want 0", o_x[0]); end
    n_vec++; if (o_y[0] !== 8'd0) begin n_err++; $display("FAIL reset y got %0d want 0", o_y[0]); end
    n_vec++; if (o_col[0] !== 3'd0) begin n_err++; $display("FAIL reset color got %0d want 0", o_col[0]); end
    n_vec++; if (bg_x[0] !== 9'd0) begin n_err++; $display("FAIL reset bg_x got %0d want 0", bg_x[0]); end
    n_vec++; if (bg_y[0] !== 8'd0) begin n_err++; $display("FAIL reset bg_y got %0d want 0", bg_y[0]); end
    n_vec++; if (spr_addr[0] !== 4'd0) begin n_err++; $display("FAIL reset spr_addr got %0d want 0", spr_addr[0]); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_erase_draw;
    int nplot;
    int k;
    logic [8:0] ex;
    logic [7:0] ey;
    logic [2:0] ec;
    sel = 0;
    fill_spr(3'b100);
    launch(2'b11, 10, 20, 11, 20);
    capture(37);
    nplot = 0;
    for (int c = 1; c <= 37; c++) begin
      n_vec++; if (cp_plot[c] !== (c >= 3 && c <= 34)) begin n_err++; $display("FAIL erase_draw plot c=%0d got %0b want %0b", c, cp_plot[c], (c >= 3 && c <= 34)); end
      n_vec++; if (cp_busy[c] !== (c >= 1 && c <= 35)) begin n_err++; $display("FAIL erase_draw busy c=%0d got %0b want %0b", c, cp_busy[c], (c >= 1 && c <= 35)); end
      n_vec++; if (cp_done[c] !== (c == 35)) begin n_err++; $display("FAIL erase_draw done c=%0d got %0b want %0b", c, cp_done[c], (c == 35)); end
      if (c >= 3 && c <= 34 && cp_plot[c] === 1'b1) begin
        nplot++;
        k = c - 3;
        if (k < 16) begin
          ex = 9'(10 + k % 4);
          ey = 8'(20 + k / 4);
          ec = 3'((int'(ex) + int'(ey)) % 8);
        end else begin
          ex = 9'(11 + (k - 16) % 4);
          ey = 8'(20 + (k - 16) / 4);
          ec = 3'b100;
        end
        n_vec++; if (cp_x[c] !== ex || cp_y[c] !== ey || cp_col[c] !== ec) begin n_err++; $display("FAIL erase_draw pixel c=%0d got (%0d,%0d,%0d) want (%0d,%0d,%0d)", c, cp_x[c], cp_y[c], cp_col[c], ex, ey, ec); end
      end
    end
    n_vec++; if (nplot != 32) begin n_err++; $display("FAIL erase_draw count got %0d want 32", nplot); end
    n_vec++; if (cp_x[3] !== 9'd10 || cp_y[3] !== 8'd20 || cp_col[3] !== 3'd6) begin n_err++; $display("FAIL erase_draw first got (%0d,%0d,%0d) want (10,20,6)", cp_x[3], cp_y[3], cp_col[3]); end
    n_vec++; if (cp_x[19] !== 9'd11 || cp_y[19] !== 8'd20 || cp_col[19] !== 3'd4) begin n_err++; $display("FAIL erase_draw draw0 got (%0d,%0d,%0d) want (11,20,4)", cp_x[19], cp_y[19], cp_col[19]); end
  endtask

  task automatic test_clip;
    int nplot;
    int k;
    logic ep;
    sel = 0;
    fill_spr(3'b011);
    launch(2'b01, 0, 0, 318, 238);
    capture(20);
    nplot = 0;
    for (int c = 1; c <= 20; c++) begin
      k  = c - 3;
      ep = (c >= 3 && c <= 18) && (k % 4 < 2) && (k / 4 < 2);
      n_vec++; if (cp_plot[c] !== ep) begin n_err++; $display("FAIL clip plot c=%0d got %0b want %0b", c, cp_plot[c], ep); end
      n_vec++; if (cp_done[c] !== (c == 19)) begin n_err++; $display("FAIL clip done c=%0d got %0b want %0b", c, cp_done[c], (c == 19)); end
      if (ep && cp_plot[c] === 1'b1) begin
        nplot++;
        n_vec++; if (cp_x[c] !== 9'(318 + k % 4) || cp_y[c] !== 8'(238 + k / 4) || cp_col[c] !== 3'd3) begin n_err++; $display("FAIL clip pixel c=%0d got (%0d,%0d,%0d) want (%0d,%0d,3)", c, cp_x[c], cp_y[c], cp_col[c], 318 + k % 4, 238 + k / 4); end
      end
    end
    n_vec++; if (nplot != 4) begin n_err++; $display("FAIL clip count got %0d want 4", nplot); end
    // Sums past 511 / 255 overflow the coordinate width and must still clip
    launch(2'b01, 0, 0, 510, 254);
    capture(20);
    for (int c = 1; c <= 20; c++) begin
      n_vec++; if (cp_plot[c] !== 1'b0) begin n_err++; $display("FAIL clip_ovf plot c=%0d got %0b want 0", c, cp_plot[c]); end
      n_vec++; if (cp_done[c] !== (c == 19)) begin n_err++; $display("FAIL clip_ovf done c=%0d got %0b want %0b", c, cp_done[c], (c == 19)); end
    end
  endtask

  task automatic test_transparent;
    int nplot;
    int k;
    logic ep;
    for (int p = 0; p < 2; p++) begin
      sel = p;
      fill_spr(3'b101);
      spr_rom[5] = (p == 0) ? 3'b000 : 3'b111;
      launch(2'b01, 0, 0, 50, 60);
      capture(20);
      nplot = 0;
      for (int c = 1; c <= 20; c++) begin
        k  = c - 3;
        ep = (c >= 3 && c <= 18) && (k != 5);
        n_vec++; if (cp_plot[c] !== ep) begin n_err++; $display("FAIL transp%0d plot c=%0d got %0b want %0b", p, c, cp_plot[c], ep); end
        if (ep && cp_plot[c] === 1'b1) begin
          nplot++;
          n_vec++; if (cp_x[c] !== 9'(50 + k % 4) || cp_y[c] !== 8'(60 + k / 4) || cp_col[c] !== 3'd5) begin n_err++; $display("FAIL transp%0d pixel c=%0d got (%0d,%0d,%0d) want (%0d,%0d,5)", p, c, cp_x[c], cp_y[c], cp_col[c], 50 + k % 4, 60 + k / 4); end
        end
      end
      n_vec++; if (nplot != 15) begin n_err++; $display("FAIL transp%0d count got %0d want 15", p, nplot); end
      n_vec++; if (cp_done[19] !== 1'b1) begin n_err++; $display("FAIL transp%0d done got %0b want 1", p, cp_done[19]); end
    end
    sel = 0;
  endtask

  task automatic test_back_to_back;
    logic eb;
    logic ep;
    sel = 0;
    fill_spr(3'b010);
    @(negedge clk);
    mode  = 2'b01;
    new_x = 9'd100;
    new_y = 8'd100;
    start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 42; c++) begin
      @(negedge clk);
      cp_plot[c] = o_plot[0];
      cp_busy[c] = o_busy[0];
      cp_done[c] = o_done[0];
      cp_x[c]    = o_x[0];
      cp_y[c]    = o_y[0];
      if (c == 5) begin
        new_x = 9'd200;
        new_y = 8'd200;
      end
      if (c == 25) start = 1'b0;
    end
    for (int c = 1; c <= 42; c++) begin
      eb = (c <= 19) || (c >= 21 && c <= 39);
      ep = (c >= 3 && c <= 18) || (c >= 23 && c <= 38);
      n_vec++; if (cp_busy[c] !== eb) begin n_err++; $display("FAIL b2b busy c=%0d got %0b want %0b", c, cp_busy[c], eb); end
      n_vec++; if (cp_plot[c] !== ep) begin n_err++; $display("FAIL b2b plot c=%0d got %0b want %0b", c, cp_plot[c], ep); end
      n_vec++; if (cp_done[c] !== (c == 19 || c == 39)) begin n_err++; $display("FAIL b2b done c=%0d got %0b want %0b", c, cp_done[c], (c == 19 || c == 39)); end
    end
    n_vec++; if (cp_x[3] !== 9'd100 || cp_y[3] !== 8'd100) begin n_err++; $display("FAIL b2b first got (%0d,%0d) want (100,100)", cp_x[3], cp_y[3]); end
    n_vec++; if (cp_x[18] !== 9'd103 || cp_y[18] !== 8'd103) begin n_err++; $display("FAIL b2b latch got (%0d,%0d) want (103,103)", cp_x[18], cp_y[18]); end
    n_vec++; if (cp_x[23] !== 9'd200 || cp_y[23] !== 8'd200) begin n_err++; $display("FAIL b2b second got (%0d,%0d) want (200,200)", cp_x[23], cp_y[23]); end
    n_vec++; if (cp_x[38] !== 9'd203 || cp_y[38] !== 8'd203) begin n_err++; $display("FAIL b2b second_last got (%0d,%0d) want (203,203)", cp_x[38], cp_y[38]); end
    // mode 00 is a no-op
    @(negedge clk);
    mode  = 2'b00;
    start = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      n_vec++; if (o_busy[0] !== 1'b0 || o_done[0] !== 1'b0 || o_plot[0] !== 1'b0) begin n_err++; $display("FAIL noop c=%0d got busy=%0b done=%0b plot=%0b want 0,0,0", c, o_busy[0], o_done[0], o_plot[0]); end
    end
    start = 1'b0;
  endtask

  task automatic test_reset_mid;
    sel = 0;
    fill_spr(3'b100);
    launch(2'b11, 10, 20, 11, 20);
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      if (c < 10) begin
        n_vec++; if (o_busy[0] !== 1'b1) begin n_err++; $display("FAIL rstmid busy c=%0d got %0b want 1", c, o_busy[0]); end
      end
      if (c >= 11) begin
        n_vec++; if (o_busy[0] !== 1'b0 || o_plot[0] !== 1'b0 || o_done[0] !== 1'b0) begin n_err++; $display("FAIL rstmid c=%0d got busy=%0b plot=%0b done=%0b want 0,0,0", c, o_busy[0], o_plot[0], o_done[0]); end
      end
      if (c == 10) rst = 1'b1;
      if (c == 11) rst = 1'b0;
    end
  endtask

  task automatic test_wide;
    int nplot;
    int k;
    logic [8:0] ex;
    logic [7:0] ey;
    logic [2:0] ec;
    sel = 2;
    launch(2'b10, 30, 40, 0, 0);
    capture(21);
    nplot = 0;
    for (int c = 1; c <= 21; c++) begin
      n_vec++; if (cp_plot[c] !== (c >= 3 && c <= 18)) begin n_err++; $display("FAIL wide plot c=%0d got %0b want %0b", c, cp_plot[c], (c >= 3 && c <= 18)); end
      n_vec++; if (cp_done[c] !== (c == 19)) begin n_err++; $display("FAIL wide done c=%0d got %0b want %0b", c, cp_done[c], (c == 19)); end
      if (c >= 3 && c <= 18 && cp_plot[c] === 1'b1) begin
        nplot++;
        k  = c - 3;
        ex = 9'(30 + k % 8);
        ey = 8'(40 + k / 8);
        ec = 3'((int'(ex) + int'(ey)) % 8);
        n_vec++; if (cp_x[c] !== ex || cp_y[c] !== ey || cp_col[c] !== ec) begin n_err++; $display("FAIL wide pixel c=%0d got (%0d,%0d,%0d) want (%0d,%0d,%0d)", c, cp_x[c], cp_y[c], cp_col[c], ex, ey, ec); end
      end
    end
    n_vec++; if (nplot != 16) begin n_err++; $display("FAIL wide count got %0d want 16", nplot); end
    n_vec++; if (cp_x[10] !== 9'd37 || cp_y[10] !== 8'd40) begin n_err++; $display("FAIL wide row0_end got (%0d,%0d) want (37,40)", cp_x[10], cp_y[10]); end
    n_vec++; if (cp_x[11] !== 9'd30 || cp_y[11] !== 8'd41 || cp_col[11] !== 3'd7) begin n_err++; $display("FAIL wide row1_start got (%0d,%0d,%0d) want (30,41,7)", cp_x[11], cp_y[11], cp_col[11]); end
    sel = 0;
  endtask

  initial begin
    fill_spr(3'b000);
    test_reset;
    test_erase_draw;
    test_clip;
    test_transparent;
    test_back_to_back;
    test_reset_mid;
    test_wide;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
